// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// One transaction is in flight at a time, moving through IDLE -> EXEC -> RESP.
// The operands and code are registered at acceptance and held as the ALU
// drive. The ALU result is captured at the end of EXEC and held until the
// consumer takes it.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every
// tie. This removes the round-robin pointer. By default, ties alternate.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Req0Valid,
    input  logic [DATA_WIDTH-1:0] Req0SrcA,
    input  logic [DATA_WIDTH-1:0] Req0SrcB,
    input  logic [2:0]            Req0Ctrl,
    output logic                  Req0Ready,
    input  logic                  Req1Valid,
    input  logic [DATA_WIDTH-1:0] Req1SrcA,
    input  logic [DATA_WIDTH-1:0] Req1SrcB,
    input  logic [2:0]            Req1Ctrl,
    output logic                  Req1Ready,
    output logic [DATA_WIDTH-1:0] SrcA,
    output logic [DATA_WIDTH-1:0] SrcB,
    output logic [2:0]            ALUControl,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic                  ZeroFlag,
    output logic                  RespValid,
    output logic                  RespId,
    output logic [DATA_WIDTH-1:0] RespResult,
    output logic                  RespZero,
    input  logic                  RespReady,
    output logic                  Busy
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0] src_b_q, src_b_d;
    logic [2:0]            alu_ctrl_q, alu_ctrl_d;
    logic                  lat_id_q, lat_id_d;
    logic                  resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
    logic                  resp_zero_q, resp_zero_d;
    logic                  grant0, grant1;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // ptr_q set means requester 1 wins the next tie
    logic                  ptr_q, ptr_d;
`endif

    // Grant decode: only in IDLE, at most one requester, ties broken by priority
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = Req0Valid;
            grant1 = Req1Valid & ~Req0Valid;
`else
            if (Req0Valid && Req1Valid) begin
                grant0 = ~ptr_q;
                grant1 = ptr_q;
            end else begin
                grant0 = Req0Valid;
                grant1 = Req1Valid;
            end
`endif
        end
    end

    // Next-state and datapath register updates for the three-phase transaction
    always_comb begin
        state_d       = state_q;
        src_a_d       = src_a_q;
        src_b_d       = src_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        lat_id_d      = lat_id_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        ptr_d         = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    src_a_d    = Req0SrcA;
                    src_b_d    = Req0SrcB;
                    alu_ctrl_d = Req0Ctrl;
                    lat_id_d   = 1'b0;
                    state_d    = EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    ptr_d      = 1'b1;
`endif
                end else if (grant1) begin
                    src_a_d    = Req1SrcA;
                    src_b_d    = Req1SrcB;
                    alu_ctrl_d = Req1Ctrl;
                    lat_id_d   = 1'b1;
                    state_d    = EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    ptr_d      = 1'b0;
`endif
                end
            end
            EXEC: begin
                // The ALU has seen the registered operands for this full cycle
                resp_result_d = ALUResult;
                resp_zero_d   = ZeroFlag;
                resp_id_d     = lat_id_q;
                state_d       = RESP;
            end
            RESP: begin
                if (RespReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction and clears outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            src_a_q       <= '0;
            src_b_q       <= '0;
            alu_ctrl_q    <= 3'b000;
            lat_id_q      <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            lat_id_q      <= lat_id_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign Req0Ready  = grant0;
    assign Req1Ready  = grant1;
    assign SrcA       = src_a_q;
    assign SrcB       = src_b_q;
    assign ALUControl = alu_ctrl_q;
    assign RespValid  = (state_q == RESP);
    assign RespId     = resp_id_q;
    assign RespResult = resp_result_q;
    assign RespZero   = resp_zero_q;
    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         Req0Valid = 1'b0, Req1Valid = 1'b0;
    logic [W-1:0] Req0SrcA = '0, Req0SrcB = '0, Req1SrcA = '0, Req1SrcB = '0;
    logic [2:0]   Req0Ctrl = 3'b0, Req1Ctrl = 3'b0;
    logic         Req0Ready, Req1Ready;
    logic [W-1:0] SrcA, SrcB, ALUResult, RespResult;
    logic [2:0]   ALUControl;
    logic         ZeroFlag, RespValid, RespId, RespZero, Busy;
    logic         RespReady = 1'b0;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .Req0Valid(Req0Valid), .Req0SrcA(Req0SrcA), .Req0SrcB(Req0SrcB), .Req0Ctrl(Req0Ctrl), .Req0Ready(Req0Ready),
        .Req1Valid(Req1Valid), .Req1SrcA(Req1SrcA), .Req1SrcB(Req1SrcB), .Req1Ctrl(Req1Ctrl), .Req1Ready(Req1Ready),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .ALUResult(ALUResult), .ZeroFlag(ZeroFlag),
        .RespValid(RespValid), .RespId(RespId), .RespResult(RespResult), .RespZero(RespZero),
        .RespReady(RespReady), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // Stand-in ALU; the unused codes return markers so forwarding is visible
    always_comb begin
        case (ALUControl)
            3'b000:  ALUResult = SrcA & SrcB;
            3'b001:  ALUResult = SrcA | SrcB;
            3'b010:  ALUResult = SrcA + SrcB;
            3'b100:  ALUResult = SrcA - SrcB;
            3'b101:  ALUResult = SrcA ^ SrcB;
            3'b110:  ALUResult = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
            3'b011:  ALUResult = 32'hC0DE_0011;
            default: ALUResult = 32'hC0DE_0111;
        endcase
        ZeroFlag = (ALUResult == '0);
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", RespValid); end
        checks++; if (RespId !== 1'b0) begin errors++; $display("FAIL rst_resp_id: got %b want 0", RespId); end
        checks++; if (RespResult !== 32'd0) begin errors++; $display("FAIL rst_resp_result: got %h want 0", RespResult); end
        checks++; if (RespZero !== 1'b0) begin errors++; $display("FAIL rst_resp_zero: got %b want 0", RespZero); end
        checks++; if (SrcA !== 32'd0 || SrcB !== 32'd0) begin errors++; $display("FAIL rst_src: got %h/%h want 0/0", SrcA, SrcB); end
        checks++; if (ALUControl !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b want 000", ALUControl); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", Busy); end
        @(negedge CLK);
        RST = 1'b1;
        #1;
    endtask

    task automatic test_req0_add();
        Req0Valid = 1'b1; Req0SrcA = 32'd5; Req0SrcB = 32'd3; Req0Ctrl = 3'b010; RespReady = 1'b0;
        #1;
        checks++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin errors++; $display("FAIL add_grant: got %b%b want 10", Req0Ready, Req1Ready); end
        tick();
        // requester keeps presenting a different op; nothing must be accepted
        Req0SrcA = 32'd100; #1;
        checks++; if (Busy !== 1'b1 || RespValid !== 1'b0) begin errors++; $display("FAIL add_exec_state: busy=%b rv=%b want 1,0", Busy, RespValid); end
        checks++; if (SrcA !== 32'd5 || SrcB !== 32'd3 || ALUControl !== 3'b010) begin errors++; $display("FAIL add_exec_drive: got %0d,%0d,%b want 5,3,010", SrcA, SrcB, ALUControl); end
        checks++; if (Req0Ready !== 1'b0) begin errors++; $display("FAIL add_exec_ready: got %b want 0", Req0Ready); end
        tick();
        checks++; if (RespValid !== 1'b1 || RespResult !== 32'd8 || RespZero !== 1'b0 || RespId !== 1'b0) begin
            errors++; $display("FAIL add_resp: got v=%b r=%0d z=%b id=%b want 1,8,0,0", RespValid, RespResult, RespZero, RespId); end
        checks++; if (Req0Ready !== 1'b0 || SrcA !== 32'd5) begin errors++; $display("FAIL add_resp_hold: ready=%b srca=%0d want 0,5", Req0Ready, SrcA); end
        Req0Valid = 1'b0; RespReady = 1'b1;
        tick();
        checks++; if (RespValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL add_release: rv=%b busy=%b want 0,0", RespValid, Busy); end
        checks++; if (SrcA !== 32'd5 || ALUControl !== 3'b010) begin errors++; $display("FAIL add_idle_hold: got %0d,%b want 5,010", SrcA, ALUControl); end
        RespReady = 1'b0;
    endtask

    task automatic test_req1_zero();
        // RespReady high early must not cut EXEC or skip RESP
        Req1Valid = 1'b1; Req1SrcA = 32'd7; Req1SrcB = 32'd7; Req1Ctrl = 3'b100; RespReady = 1'b1;
        #1;
        checks++; if (Req1Ready !== 1'b1 || Req0Ready !== 1'b0) begin errors++; $display("FAIL zero_grant: got %b%b want 01", Req0Ready, Req1Ready); end
        tick();
        Req1Valid = 1'b0; #1;
        checks++; if (RespValid !== 1'b0 || ALUControl !== 3'b100) begin errors++; $display("FAIL zero_exec: rv=%b ctrl=%b want 0,100", RespValid, ALUControl); end
        tick();
        checks++; if (RespValid !== 1'b1 || RespResult !== 32'd0 || RespZero !== 1'b1 || RespId !== 1'b1) begin
            errors++; $display("FAIL zero_resp: got v=%b r=%0d z=%b id=%b want 1,0,1,1", RespValid, RespResult, RespZero, RespId); end
        tick();
        checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL zero_release: got %b want 0", RespValid); end
        RespReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_id;
        logic got_id;
        logic found;
        Req0Valid = 1'b1; Req0SrcA = 32'd1;  Req0SrcB = 32'd2; Req0Ctrl = 3'b010;
        Req1Valid = 1'b1; Req1SrcA = 32'd10; Req1SrcB = 32'd4; Req1Ctrl = 3'b100;
        RespReady = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = k[0];
`endif
            found = 1'b0; got_id = 1'b0;
            for (int c = 0; c < 6 && !found; c++) begin
                if (Req0Ready && Req1Ready) begin
                    checks++; errors++; $display("FAIL b2b_both_ready: got 11 want one-hot");
                end
                if (Req0Ready || Req1Ready) begin
                    found = 1'b1; got_id = Req1Ready;
                end else begin
                    tick();
                end
            end
            checks++; if (!found) begin errors++; $display("FAIL b2b_timeout: no grant for txn %0d", k); end
            checks++; if (got_id !== exp_id) begin errors++; $display("FAIL b2b_grant: txn %0d got %b want %b", k, got_id, exp_id); end
            tick();
            tick();
            checks++; if (RespValid !== 1'b1 || RespId !== exp_id || RespResult !== (exp_id ? 32'd6 : 32'd3)) begin
                errors++; $display("FAIL b2b_resp: txn %0d got v=%b id=%b r=%0d want 1,%b,%0d", k, RespValid, RespId, RespResult, exp_id, exp_id ? 6 : 3); end
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        tick();
        RespReady = 1'b0;
    endtask

    task automatic test_resp_hold();
        Req0Valid = 1'b1; Req0SrcA = 32'd2; Req0SrcB = 32'd9; Req0Ctrl = 3'b110;
        Req1Valid = 1'b1; Req1SrcA = 32'd1; Req1SrcB = 32'd1; Req1Ctrl = 3'b000;
        RespReady = 1'b0;
        #1;
        checks++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin errors++; $display("FAIL hold_grant: got %b%b want 10", Req0Ready, Req1Ready); end
        tick();
        Req0Valid = 1'b0; #1;
        checks++; if (Req1Ready !== 1'b0) begin errors++; $display("FAIL hold_exec_r1: got %b want 0", Req1Ready); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (RespValid !== 1'b1 || RespResult !== 32'd1 || RespZero !== 1'b0 || RespId !== 1'b0) begin
                errors++; $display("FAIL hold_resp: cycle %0d got v=%b r=%0d z=%b id=%b want 1,1,0,0", i, RespValid, RespResult, RespZero, RespId); end
            checks++; if (Req1Ready !== 1'b0 || SrcA !== 32'd2 || ALUControl !== 3'b110) begin
                errors++; $display("FAIL hold_side: cycle %0d r1=%b srca=%0d ctrl=%b want 0,2,110", i, Req1Ready, SrcA, ALUControl); end
            tick();
        end
        Req1Valid = 1'b0; RespReady = 1'b1;
        tick();
        checks++; if (RespValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL hold_release: rv=%b busy=%b want 0,0", RespValid, Busy); end
        RespReady = 1'b0;
    endtask

    task automatic test_unused_ctrl();
        logic [2:0]   code;
        logic [W-1:0] mark;
        for (int n = 0; n < 2; n++) begin
            code = (n == 0) ? 3'b111 : 3'b011;
            mark = (n == 0) ? 32'hC0DE_0111 : 32'hC0DE_0011;
            if (n == 0) begin Req1Valid = 1'b1; Req1SrcA = 32'd3; Req1SrcB = 32'd4; Req1Ctrl = code; end
            else        begin Req0Valid = 1'b1; Req0SrcA = 32'd3; Req0SrcB = 32'd4; Req0Ctrl = code; end
            #1;
            tick();
            Req0Valid = 1'b0; Req1Valid = 1'b0; #1;
            checks++; if (ALUControl !== code) begin errors++; $display("FAIL unused_fwd: got %b want %b", ALUControl, code); end
            tick();
            checks++; if (RespValid !== 1'b1 || RespResult !== mark || RespId !== (n == 0)) begin
                errors++; $display("FAIL unused_resp: got v=%b r=%h id=%b want 1,%h,%b", RespValid, RespResult, RespId, mark, n == 0); end
            RespReady = 1'b1;
            tick();
            RespReady = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        Req0Valid = 1'b1; Req0SrcA = 32'd6; Req0SrcB = 32'd1; Req0Ctrl = 3'b010;
        #1;
        checks++; if (Req0Ready !== 1'b1) begin errors++; $display("FAIL arst_pre_grant: got %b want 1", Req0Ready); end
        tick();
        Req0Valid = 1'b0; #1;
        checks++; if (Busy !== 1'b1 || SrcA !== 32'd6) begin errors++; $display("FAIL arst_exec: busy=%b srca=%0d want 1,6", Busy, SrcA); end
        RST = 1'b0;
        #1;
        checks++; if (RespValid !== 1'b0 || RespId !== 1'b0 || RespResult !== 32'd0 || RespZero !== 1'b0) begin
            errors++; $display("FAIL arst_resp: got v=%b id=%b r=%h z=%b want all 0", RespValid, RespId, RespResult, RespZero); end
        checks++; if (SrcA !== 32'd0 || SrcB !== 32'd0 || ALUControl !== 3'b000 || Busy !== 1'b0) begin
            errors++; $display("FAIL arst_drive: got %h,%h,%b busy=%b want 0,0,000,0", SrcA, SrcB, ALUControl, Busy); end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (RespValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL arst_after: cycle %0d rv=%b busy=%b want 0,0", i, RespValid, Busy); end
            tick();
        end
        // pointer must be back to favouring requester 0
        Req0Valid = 1'b1; Req0SrcA = 32'd6; Req0SrcB = 32'd1; Req0Ctrl = 3'b010;
        Req1Valid = 1'b1; Req1SrcA = 32'd0; Req1SrcB = 32'd0; Req1Ctrl = 3'b001;
        #1;
        checks++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin errors++; $display("FAIL arst_tie: got %b%b want 10", Req0Ready, Req1Ready); end
        tick();
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        tick();
        checks++; if (RespValid !== 1'b1 || RespResult !== 32'd7 || RespId !== 1'b0) begin
            errors++; $display("FAIL arst_new_txn: got v=%b r=%0d id=%b want 1,7,0", RespValid, RespResult, RespId); end
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_req0_add();
        test_req1_zero();
        test_back_to_back();
        test_resp_hold();
        test_unused_ctrl();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; SHALL match the ALU datapath width.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 Req0Valid / Req1Valid  input  1 each  requester n presents an operation.
REQ-005 Req0SrcA, Req0SrcB / Req1SrcA, Req1SrcB  input  DATA_WIDTH each  operands of requester n.
REQ-006 Req0Ctrl / Req1Ctrl  input  3 each  ALUControl code of requester n.
REQ-007 Req0Ready / Req1Ready  output  1 each  requester n's operation is accepted this cycle.
REQ-008 SrcA, SrcB  output  DATA_WIDTH  operands driven to the shared ALU.
REQ-009 ALUControl  output  3  operation code driven to the shared ALU.
REQ-010 ALUResult  input  DATA_WIDTH; ZeroFlag  input  1  combinational ALU outputs.
REQ-011 RespValid  output  1  response held for the consumer.
REQ-012 RespId  output  1  requester index owning the response.
REQ-013 RespResult  output  DATA_WIDTH; RespZero  output  1  captured ALU result and zero flag.
REQ-014 RespReady  input  1  consumer accepts the response.
REQ-015 Busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; at most one transaction in flight.
REQ-017 IDLE: ReqnReady SHALL be 1 only for the granted requester, combinationally from Valid inputs and pointer; never both high.
REQ-018 Handshake ReqnValid & ReqnReady in IDLE SHALL latch that requester's SrcA, SrcB, Ctrl and index into internal registers and go to EXEC.
REQ-019 Round-robin: one valid requester SHALL be granted; both valid SHALL grant the requester not granted last; pointer updates only on handshake.
REQ-020 EXEC (exactly one cycle): SrcA, SrcB, ALUControl SHALL be driven from latched registers; ALUResult and ZeroFlag SHALL be captured into RespResult/RespZero at cycle end; next state RESP.
REQ-021 Outside EXEC, SrcA, SrcB, ALUControl SHALL hold their last driven values (no toggling in IDLE/RESP).
REQ-022 RESP: RespValid=1, RespId, RespResult, RespZero stable until RespValid & RespReady; then IDLE.
REQ-023 Latency: handshake in cycle N -> RespValid first high in cycle N+2; with RespReady held 1, back-to-back accept every 3 cycles.
REQ-024 No new request SHALL be accepted while in EXEC or RESP; requesters hold Valid and data until Ready.
REQ-025 ALUControl codes (incl. unused 011, 111) SHALL be forwarded unmodified; result returned as the ALU produced it.
REQ-026 RespReady while not in RESP SHALL be ignored.

Reset
REQ-027 RST low SHALL immediately force IDLE, RespValid=0, RespId=0, RespResult=0, RespZero=0, SrcA=0, SrcB=0, ALUControl=0, Busy=0, pointer so requester 0 wins the first tie.
REQ-028 Reset in EXEC or RESP SHALL discard the transaction; no response SHALL issue after release.
REQ-029 First acceptance no earlier than the first rising CLK edge after RST deasserts.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 SHALL always win ties, pointer logic removed; undefined -> round-robin per REQ-019.

Verification
REQ-031 Req0 only: SrcA=5, SrcB=3, Ctrl=010 -> Req0Ready in cycle N, RespValid cycle N+2, RespResult=8, RespZero=0, RespId=0.
REQ-032 Req1: SrcA=7, SrcB=7, Ctrl=100 -> RespResult=0, RespZero=1, RespId=1.
REQ-033 Both valid continuously, RespReady=1 -> grants alternate 0,1,0,1 (default); macro defined -> all grants to 0.
REQ-034 Req0 Ctrl=110, SrcA=2, SrcB=9; RespReady=0 for 5 cycles -> RespValid, RespResult=1 held stable; Req1Ready stays 0 throughout.
REQ-035 RST low during EXEC -> all outputs 0 asynchronously; after release no RespValid until a new handshake.
